tlut_pulse_decode: RTL and testbench

TLUT_PULSE_DECODE -- requirements
Module: tlut_pulse_decode

---
 rtl/tlut_pkg.sv | 29 ++
 rtl/tlut_lane_capture.sv | 50 +++++
 rtl/tlut_pulse_decode.sv | 119 +++++++++++
 tb/tb_tlut_pulse_decode.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlut_pkg.sv
// ---------------------------------------------------------------------------
// tlut_pkg
// Shared definitions for the temporal-pulse decoder slice.
//   - Default geometry / width macros (normally supplied by DEF.sv; the
//     guarded fallbacks below keep the package self-contained).
//   - state_t : IDLE / RUN / DONE states of the decode window FSM.
// ---------------------------------------------------------------------------
`ifndef DIM_ROW1
`define DIM_ROW1 2
`endif
`ifndef DIM_COL1
`define DIM_COL1 2
`endif
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 4
`endif

package tlut_pkg;

   localparam int DEF_N_LANE = `DIM_ROW1 * `DIM_COL1;
   localparam int DEF_W      = `INPUT_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/tlut_lane_capture.sv
// ---------------------------------------------------------------------------
// tlut_lane_capture
// Captures one lane of a temporal pulse code: the first sampled pulse latches
// the current ramp value, any later sampled pulse flags an error.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : start of a new window, empties the lane
//   sample     : ramp is advancing this cycle (RUN and enable)
//   pulse      : lane pulse input
//   cnt        : current ramp value
//   data       : ramp value at the first pulse (0 if none)
//   hit        : lane has seen a pulse in this window
//   err        : lane pulsed on more than one sampled cycle
// ---------------------------------------------------------------------------
module tlut_lane_capture #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         sample,
   input  logic         pulse,
   input  logic [W-1:0] cnt,
   output logic [W-1:0] data,
   output logic         hit,
   output logic         err
);

   // First pulse wins the data slot; repeats only raise err so the
   // captured value is never overwritten within a window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data <= '0;
         hit  <= 1'b0;
         err  <= 1'b0;
      end else if (clear) begin
         data <= '0;
         hit  <= 1'b0;
         err  <= 1'b0;
      end else if (sample && pulse) begin
         if (!hit) begin
            data <= cnt;
            hit  <= 1'b1;
         end else begin
            err  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/tlut_pulse_decode.sv
// ---------------------------------------------------------------------------
// tlut_pulse_decode
// Decodes temporally encoded lane pulses back into values. A ramp counter
// sweeps 0 .. 2^W-1 once per window; each lane records the ramp value at
// which its pulse arrived. Result is held under a valid/ready handshake.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   enable     : ramp advances / lanes sampled when high, stall when low
//   start      : request a new decode window
//   pulse_in   : per-lane temporal pulses
//   rng        : current ramp value to the encoder comparators
//   busy       : window in progress (RUN)
//   out_valid  : decoded result available (DONE)
//   out_ready  : consumer accepts the result
//   out_data   : decoded lane values
//   out_hit    : lane received a pulse
//   out_err    : lane pulsed more than once
// ---------------------------------------------------------------------------
`ifndef DIM_ROW1
`define DIM_ROW1 2
`endif
`ifndef DIM_COL1
`define DIM_COL1 2
`endif
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 4
`endif

module tlut_pulse_decode
   import tlut_pkg::*;
#(
   parameter int N_LANE = `DIM_ROW1 * `DIM_COL1,
   parameter int W      = `INPUT_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic                         start,
   input  logic [N_LANE-1:0]            pulse_in,
   output logic [W-1:0]                 rng,
   output logic                         busy,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [N_LANE-1:0][W-1:0]     out_data,
   output logic [N_LANE-1:0]            out_hit,
   output logic [N_LANE-1:0]            out_err
);

   localparam logic [W-1:0] CNT_MAX = '1;

   state_t       state;
   state_t       state_next;
   logic [W-1:0] cnt;
   logic         clear;
   logic         sample;

   // A new window opens from IDLE, or straight from DONE when the result
   // is being accepted in the same cycle; start is ignored otherwise.
   assign clear  = start && ((state == IDLE) || ((state == DONE) && out_ready));
   assign sample = (state == RUN) && enable;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. The last ramp value is sampled on the transition
   // to DONE, so there is never a second pass through the ramp.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (start) state_next = RUN;
         RUN:  if (enable && (cnt == CNT_MAX)) state_next = DONE;
         DONE: begin
            if (out_ready) state_next = start ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decodes of the registered state.
   always_comb begin
      busy      = (state == RUN);
      out_valid = (state == DONE);
   end

   // Ramp counter: the natural W-bit wrap on the final sample returns it to
   // zero exactly as the FSM leaves RUN, and it is forced to zero elsewhere.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state != RUN) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign rng = cnt;

   for (genvar i = 0; i < N_LANE; i++) begin : g_lane
      tlut_lane_capture #(.W(W)) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .clear  (clear),
         .sample (sample),
         .pulse  (pulse_in[i]),
         .cnt    (cnt),
         .data   (out_data[i]),
         .hit    (out_hit[i]),
         .err    (out_err[i])
      );
   end

endmodule

// File: tb/tb_tlut_pulse_decode.sv
// ---------------------------------------------------------------------------
// tb_tlut_pulse_decode
// Directed bench for tlut_pulse_decode with W=4, N_LANE=4. A small encoder
// model drives pulse_in from the ramp: each lane can pulse at up to two ramp
// values, plus a forced pulse for stall tests.
// ---------------------------------------------------------------------------
module tb_tlut_pulse_decode;

   localparam int W      = 4;
   localparam int N_LANE = 4;

   logic                     clk;
   logic                     rst_n;
   logic                     enable;
   logic                     start;
   logic [N_LANE-1:0]        pulse_in;
   logic [W-1:0]             rng;
   logic                     busy;
   logic                     out_valid;
   logic                     out_ready;
   logic [N_LANE-1:0][W-1:0] out_data;
   logic [N_LANE-1:0]        out_hit;
   logic [N_LANE-1:0]        out_err;

   logic [W-1:0]             val_a [N_LANE];
   logic [W-1:0]             val_b [N_LANE];
   logic [N_LANE-1:0]        en_a;
   logic [N_LANE-1:0]        en_b;
   logic [N_LANE-1:0]        force_pulse;

   int checks;
   int failures;
   int n;

   logic [N_LANE-1:0][W-1:0] held_data;
   logic [N_LANE-1:0]        held_hit;
   logic [N_LANE-1:0]        held_err;
   logic                     stable_ok;
   logic                     valid_seen;

   tlut_pulse_decode #(.N_LANE(N_LANE), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .start     (start),
      .pulse_in  (pulse_in),
      .rng       (rng),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_hit   (out_hit),
      .out_err   (out_err)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Encoder model: a lane pulses while the ramp matches one of its values.
   always_comb begin
      for (int i = 0; i < N_LANE; i++) begin
         pulse_in[i] = (en_a[i] && (rng == val_a[i])) ||
                       (en_b[i] && (rng == val_b[i])) ||
                       force_pulse[i];
      end
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Pulse start for one edge, then count further edges until out_valid.
   // Result n includes the edge that captured start; -1 on timeout.
   task automatic applyStimulus(output int cnt_edges);
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt_edges = 1;
      while (!out_valid && cnt_edges < 100) begin
         tick();
         cnt_edges++;
      end
      if (!out_valid) cnt_edges = -1;
   endtask

   task automatic set_lanes(input logic [15:0] a, input logic [3:0] ea,
                            input logic [15:0] b, input logic [3:0] eb);
      for (int i = 0; i < N_LANE; i++) begin
         val_a[i] = a[i*4 +: 4];
         val_b[i] = b[i*4 +: 4];
      end
      en_a = ea;
      en_b = eb;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      enable      = 1'b1;
      start       = 1'b1;
      out_ready   = 1'b0;
      force_pulse = '0;
      set_lanes(16'h0000, 4'h0, 16'h0000, 4'h0);

      // Reset held with start high: must stay idle and empty.
      tick();
      tick();
      checkOutput("reset_busy",  busy,      1'b0);
      checkOutput("reset_valid", out_valid, 1'b0);
      checkOutput("reset_rng",   rng,       4'd0);
      checkOutput("reset_hit",   out_hit,   4'h0);
      checkOutput("reset_data",  out_data,  16'h0000);
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      checkOutput("idle_busy", busy, 1'b0);

      // Lanes {3,0,15,7}, one pulse each.
      $display("[TB] basic decode");
      set_lanes(16'h7F03, 4'hF, 16'h0000, 4'h0);
      applyStimulus(n);
      checkOutput("basic_latency", n,         17);
      checkOutput("basic_data",    out_data,  16'h7F03);
      checkOutput("basic_hit",     out_hit,   4'hF);
      checkOutput("basic_err",     out_err,   4'h0);
      checkOutput("basic_busy",    busy,      1'b0);
      consume();
      checkOutput("basic_to_idle", out_valid, 1'b0);
      checkOutput("basic_idle_busy", busy,    1'b0);

      // Lane 2 pulses at 5 and 9; lane 3 silent; lanes 0/1 at 1 and 12.
      $display("[TB] double pulse / silent lane");
      set_lanes(16'h05C1, 4'h7, 16'h0900, 4'h4);
      applyStimulus(n);
      checkOutput("dbl_latency", n,        17);
      checkOutput("dbl_data",    out_data, 16'h05C1);
      checkOutput("dbl_hit",     out_hit,  4'h7);
      checkOutput("dbl_err",     out_err,  4'h4);
      consume();

      // Stall 3 cycles at cnt=6 with a forced pulse on silent lane 3.
      $display("[TB] enable stall");
      set_lanes(16'h0F03, 4'h7, 16'h0000, 4'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (rng != 4'd6 && n < 100) begin
         tick();
         n++;
      end
      enable      = 1'b0;
      force_pulse = 4'h8;
      stable_ok   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n++;
         if (rng != 4'd6 || !busy) stable_ok = 1'b0;
      end
      checkOutput("stall_hold_rng", stable_ok, 1'b1);
      enable      = 1'b1;
      force_pulse = 4'h0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      checkOutput("stall_latency", n,        20);
      checkOutput("stall_data",    out_data, 16'h0F03);
      checkOutput("stall_hit",     out_hit,  4'h7);
      checkOutput("stall_err",     out_err,  4'h0);

      // Hold DONE with out_ready low for 5 cycles, start ignored meanwhile.
      $display("[TB] backpressure and back-to-back start");
      held_data = out_data;
      held_hit  = out_hit;
      held_err  = out_err;
      stable_ok = 1'b1;
      start     = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (!out_valid || busy || out_data !== held_data ||
             out_hit !== held_hit || out_err !== held_err) stable_ok = 1'b0;
      end
      checkOutput("bp_stable", stable_ok, 1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      checkOutput("b2b_busy",  busy,      1'b1);
      checkOutput("b2b_valid", out_valid, 1'b0);
      checkOutput("b2b_rng",   rng,       4'd0);
      checkOutput("b2b_hit",   out_hit,   4'h0);
      n = 1;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      checkOutput("b2b_latency", n,        17);
      checkOutput("b2b_data",    out_data, 16'h0F03);
      consume();

      // Reset for one cycle at cnt=8 aborts the window.
      $display("[TB] mid-window reset");
      set_lanes(16'h7F03, 4'hF, 16'h0000, 4'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (rng != 4'd8 && n < 100) begin
         tick();
         n++;
      end
      checkOutput("rst_reached8", rng, 4'd8);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("rst_busy", busy,    1'b0);
      checkOutput("rst_rng",  rng,     4'd0);
      checkOutput("rst_hit",  out_hit, 4'h0);
      valid_seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (out_valid || busy) valid_seen = 1'b1;
      end
      checkOutput("rst_no_valid", valid_seen, 1'b0);

      // Start pulsed again at cnt=4 must not restart the window.
      $display("[TB] start during RUN");
      set_lanes(16'hA2E1, 4'hF, 16'h0000, 4'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (rng != 4'd4 && n < 100) begin
         tick();
         n++;
      end
      start = 1'b1;
      tick();
      n++;
      start = 1'b0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      checkOutput("rerun_latency", n,        17);
      checkOutput("rerun_data",    out_data, 16'hA2E1);
      checkOutput("rerun_hit",     out_hit,  4'hF);
      consume();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
